// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap sequencer.
package trap_pkg;

    localparam int unsigned CODE_W = 4;

    // Synchronous exception cause codes
    localparam logic [CODE_W-1:0] CAUSE_FETCH_MISALIGN = 4'd0;
    localparam logic [CODE_W-1:0] CAUSE_ILLEGAL        = 4'd2;
    localparam logic [CODE_W-1:0] CAUSE_BREAKPOINT     = 4'd3;
    localparam logic [CODE_W-1:0] CAUSE_LOAD_MISALIGN  = 4'd4;
    localparam logic [CODE_W-1:0] CAUSE_STORE_MISALIGN = 4'd6;
    localparam logic [CODE_W-1:0] CAUSE_ECALL_U        = 4'd8;

    // Machine interrupt codes, also their bit positions in mip/mie
    localparam logic [CODE_W-1:0] IRQ_MSI = 4'd3;
    localparam logic [CODE_W-1:0] IRQ_MTI = 4'd7;
    localparam logic [CODE_W-1:0] IRQ_MEI = 4'd11;

    // mstatus fields
    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    // Privilege levels
    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_S = 2'b01;
    localparam logic [1:0] PRIV_M = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_TRAP_COMMIT = 2'd1;
    localparam logic [1:0] ST_RET_COMMIT  = 2'd2;
    localparam logic [1:0] ST_REDIRECT    = 2'd3;

    // ecall cause follows the caller privilege: U 8, S 9, M 11
    function automatic logic [CODE_W-1:0] ecall_cause(input logic [1:0] priv);
        return CAUSE_ECALL_U + CODE_W'(priv);
    endfunction

endpackage

// File: rtl/trap_cause_prio.sv
// Priority encoder: exception/interrupt flags -> cause code, mtval, interrupt flag.
module trap_cause_prio
    import trap_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic              fetch_misalign,
    input  logic              illegal_instr,
    input  logic              csr_exc_en,
    input  logic [CODE_W-1:0] csr_exc_code,
    input  logic [XLEN-1:0]   csr_exc_val,
    input  logic              ebreak,
    input  logic              ecall,
    input  logic [1:0]        priv_lvl,
    input  logic              ls_misalign,
    input  logic              ls_is_store,
    input  logic [XLEN-1:0]   ls_addr,
    input  logic [XLEN-1:0]   pc_addr,
    input  logic [2:0]        irq_pend,   // {MEI, MSI, MTI}, already globally gated
    output logic              exc_c,
    output logic              irq_c,
    output logic [CODE_W-1:0] code_c,
    output logic [XLEN-1:0]   tval_c,
    output logic              is_irq_c
);

    // Highest-priority exception first, interrupts only when no exception
    always_comb begin
        exc_c    = fetch_misalign | illegal_instr | csr_exc_en | ebreak | ecall | ls_misalign;
        irq_c    = |irq_pend;
        code_c   = '0;
        tval_c   = '0;
        is_irq_c = 1'b0;
        if (fetch_misalign) begin
            code_c = CAUSE_FETCH_MISALIGN;
            tval_c = pc_addr;
        end else if (illegal_instr) begin
            code_c = CAUSE_ILLEGAL;
        end else if (csr_exc_en) begin
            code_c = csr_exc_code;
            tval_c = csr_exc_val;
        end else if (ebreak) begin
            code_c = CAUSE_BREAKPOINT;
            tval_c = pc_addr;
        end else if (ecall) begin
            code_c = ecall_cause(priv_lvl);
        end else if (ls_misalign) begin
            code_c = ls_is_store ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
            tval_c = ls_addr;
        end else if (irq_pend[2]) begin
            code_c   = IRQ_MEI;
            is_irq_c = 1'b1;
        end else if (irq_pend[1]) begin
            code_c   = IRQ_MSI;
            is_irq_c = 1'b1;
        end else if (irq_pend[0]) begin
            code_c   = IRQ_MTI;
            is_irq_c = 1'b1;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: exception/interrupt entry and MRET return for the machine CSR file.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int unsigned XLEN       = 64,
    parameter logic [1:0]  RESET_PRIV = 2'b11,
    parameter bit          VEC_EN     = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] pc_addr,
    input  logic            fetch_misalign,
    input  logic            csr_exc_en,
    input  logic [3:0]      csr_exc_code,
    input  logic [XLEN-1:0] csr_exc_val,
    input  logic            illegal_instr,
    input  logic            ebreak,
    input  logic            ecall,
    input  logic            ls_misalign,
    input  logic            ls_is_store,
    input  logic [XLEN-1:0] ls_addr,
    input  logic            mret,
    input  logic [XLEN-1:0] mstatus_current,
    input  logic [XLEN-1:0] mtvec,
    input  logic [XLEN-1:0] mepc,
    input  logic [XLEN-1:0] mcause_cur,
    input  logic [XLEN-1:0] mtval_cur,
    input  logic [XLEN-1:0] mie,
    input  logic [XLEN-1:0] mip,
    output logic            trap_taken,
    output logic            trap_done,
    output logic [XLEN-1:0] mepc_next,
    output logic [XLEN-1:0] mcause_next,
    output logic [XLEN-1:0] mtval_next,
    output logic [XLEN-1:0] mstatus_next,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            stall,
    output logic [1:0]      priv_lvl
);

    logic [1:0]        state_q, state_d;
    logic [XLEN-1:0]   pend;
    logic              irq_glob_en;
    logic [2:0]        irq_vec;
    logic              illegal_any;
    logic              exc_c, irq_c, is_irq_c, event_c;
    logic [CODE_W-1:0] code_c;
    logic [XLEN-1:0]   tval_c;
    logic [XLEN-1:0]   mepc_d, mcause_d, mtval_d, mstatus_d, target_d;
    logic [1:0]        priv_d, new_priv_q, mpp;
    logic              unused_bits;

    assign pend        = mip & mie;
    assign irq_glob_en = (priv_lvl != PRIV_M) || mstatus_current[MSTATUS_MIE];
    assign irq_vec     = irq_glob_en ? {pend[IRQ_MEI], pend[IRQ_MSI], pend[IRQ_MTI]} : 3'b000;
    // MRET below M-mode is reported as an illegal instruction
    assign illegal_any = illegal_instr | (mret & (priv_lvl != PRIV_M));
    assign mpp         = mstatus_current[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
    assign event_c     = instr_valid & (exc_c | irq_c | mret);
    assign unused_bits = ^{mepc[1:0], pend};

    trap_cause_prio #(.XLEN(XLEN)) u_prio (
        .fetch_misalign (fetch_misalign),
        .illegal_instr  (illegal_any),
        .csr_exc_en     (csr_exc_en),
        .csr_exc_code   (csr_exc_code),
        .csr_exc_val    (csr_exc_val),
        .ebreak         (ebreak),
        .ecall          (ecall),
        .priv_lvl       (priv_lvl),
        .ls_misalign    (ls_misalign),
        .ls_is_store    (ls_is_store),
        .ls_addr        (ls_addr),
        .pc_addr        (pc_addr),
        .irq_pend       (irq_vec),
        .exc_c          (exc_c),
        .irq_c          (irq_c),
        .code_c         (code_c),
        .tval_c         (tval_c),
        .is_irq_c       (is_irq_c)
    );

    // CSR update values and fetch target for trap entry or MRET
    always_comb begin
        mepc_d    = mepc;
        mcause_d  = mcause_cur;
        mtval_d   = mtval_cur;
        mstatus_d = mstatus_current;
        target_d  = {mepc[XLEN-1:2], 2'b00};
        priv_d    = (mpp == 2'b10) ? PRIV_U : mpp;
        if (exc_c | irq_c) begin
            mepc_d                                   = {pc_addr[XLEN-1:1], 1'b0};
            mcause_d                                 = XLEN'(code_c);
            mcause_d[XLEN-1]                         = is_irq_c;
            mtval_d                                  = tval_c;
            mstatus_d[MSTATUS_MPIE]                  = mstatus_current[MSTATUS_MIE];
            mstatus_d[MSTATUS_MIE]                   = 1'b0;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = priv_lvl;
            target_d                                 = {mtvec[XLEN-1:2], 2'b00};
            // MODE 2/3 falls through to direct
            if (VEC_EN && is_irq_c && (mtvec[1:0] == 2'b01))
                target_d = target_d + XLEN'({code_c, 2'b00});
            priv_d = PRIV_M;
        end else begin
            mstatus_d[MSTATUS_MIE]                   = mstatus_current[MSTATUS_MPIE];
            mstatus_d[MSTATUS_MPIE]                  = 1'b1;
            mstatus_d[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        end
    end

    // Next-state and stall; inputs only matter in IDLE
    always_comb begin
        state_d = state_q;
        stall   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                stall = event_c;
                if (event_c)
                    state_d = (exc_c | irq_c) ? ST_TRAP_COMMIT : ST_RET_COMMIT;
            end
            ST_TRAP_COMMIT, ST_RET_COMMIT: state_d = ST_REDIRECT;
            ST_REDIRECT:                   state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Registered pulses, latched CSR values, redirect target and privilege
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_taken     <= 1'b0;
            trap_done      <= 1'b0;
            redirect_valid <= 1'b0;
            mepc_next      <= '0;
            mcause_next    <= '0;
            mtval_next     <= '0;
            mstatus_next   <= '0;
            redirect_pc    <= '0;
            new_priv_q     <= RESET_PRIV;
            priv_lvl       <= RESET_PRIV;
        end else begin
            trap_taken     <= (state_d == ST_TRAP_COMMIT);
            trap_done      <= (state_d == ST_RET_COMMIT);
            redirect_valid <= (state_d == ST_REDIRECT);
            if ((state_q == ST_IDLE) && event_c) begin
                mepc_next    <= mepc_d;
                mcause_next  <= mcause_d;
                mtval_next   <= mtval_d;
                mstatus_next <= mstatus_d;
                redirect_pc  <= target_d;
                new_priv_q   <= priv_d;
            end
            if ((state_q == ST_TRAP_COMMIT) || (state_q == ST_RET_COMMIT))
                priv_lvl <= new_priv_q;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed table, random stimulus vs. reference model, reset abort.
module tb_trap_ctrl;

    typedef struct {
        logic        valid, fm, ill, csr, eb, ec, lsm, lss, mret;
        logic [3:0]  csr_code;
        logic [63:0] csr_val, ls_addr, pc, mstatus, mtvec, mepc, mcause, mtval, mie, mip;
    } stim_t;

    typedef struct {
        logic        is_ret;
        logic [63:0] mepc, mcause, mtval, mstatus, target;
        logic [1:0]  priv;
    } exp_t;

    typedef struct {
        logic [1:0] pre;
        stim_t      s;
        exp_t       e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        instr_valid, fetch_misalign, csr_exc_en, illegal_instr, ebreak, ecall;
    logic        ls_misalign, ls_is_store, mret;
    logic [3:0]  csr_exc_code;
    logic [63:0] pc_addr, csr_exc_val, ls_addr, mstatus_current, mtvec, mepc, mcause_cur, mtval_cur, mie, mip;
    logic        trap_taken, trap_done, redirect_valid, stall;
    logic [63:0] mepc_next, mcause_next, mtval_next, mstatus_next, redirect_pc;
    logic [1:0]  priv_lvl;

    int          checks = 0;
    int          failures = 0;
    logic [1:0]  model_priv = 2'd3;

    always #5 clk = ~clk;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_addr(pc_addr),
        .fetch_misalign(fetch_misalign), .csr_exc_en(csr_exc_en), .csr_exc_code(csr_exc_code),
        .csr_exc_val(csr_exc_val), .illegal_instr(illegal_instr), .ebreak(ebreak), .ecall(ecall),
        .ls_misalign(ls_misalign), .ls_is_store(ls_is_store), .ls_addr(ls_addr), .mret(mret),
        .mstatus_current(mstatus_current), .mtvec(mtvec), .mepc(mepc), .mcause_cur(mcause_cur),
        .mtval_cur(mtval_cur), .mie(mie), .mip(mip), .trap_taken(trap_taken), .trap_done(trap_done),
        .mepc_next(mepc_next), .mcause_next(mcause_next), .mtval_next(mtval_next),
        .mstatus_next(mstatus_next), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall), .priv_lvl(priv_lvl)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic stim_t blank();
        stim_t s;
        s = '{default: '0};
        s.valid = 1'b1;
        return s;
    endfunction

    function automatic stim_t rand_stim(input bit force_valid);
        stim_t s;
        s.valid    = force_valid ? 1'b1 : ($urandom_range(0, 9) != 0);
        s.fm       = ($urandom_range(0, 7) == 0);
        s.ill      = ($urandom_range(0, 7) == 0);
        s.csr      = ($urandom_range(0, 7) == 0);
        s.eb       = ($urandom_range(0, 7) == 0);
        s.ec       = ($urandom_range(0, 6) == 0);
        s.lsm      = ($urandom_range(0, 6) == 0);
        s.lss      = 1'($urandom_range(0, 1));
        s.mret     = ($urandom_range(0, 2) == 0);
        s.csr_code = 4'd2;
        s.csr_val  = rnd64();
        s.ls_addr  = rnd64();
        s.pc       = rnd64();
        s.mstatus  = rnd64();
        s.mtvec    = rnd64();
        s.mepc     = rnd64();
        s.mcause   = rnd64();
        s.mtval    = rnd64();
        s.mie      = {52'd0, 1'($urandom_range(0, 1)), 3'd0, 1'($urandom_range(0, 1)), 3'd0, 1'($urandom_range(0, 1)), 3'd0};
        s.mip      = {52'd0, 1'($urandom_range(0, 1)), 3'd0, 1'($urandom_range(0, 1)), 3'd0, 1'($urandom_range(0, 1)), 3'd0};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        instr_valid = s.valid;    fetch_misalign = s.fm;   illegal_instr = s.ill;
        csr_exc_en = s.csr;       csr_exc_code = s.csr_code; csr_exc_val = s.csr_val;
        ebreak = s.eb;            ecall = s.ec;            ls_misalign = s.lsm;
        ls_is_store = s.lss;      ls_addr = s.ls_addr;     mret = s.mret;
        pc_addr = s.pc;           mstatus_current = s.mstatus; mtvec = s.mtvec;
        mepc = s.mepc;            mcause_cur = s.mcause;   mtval_cur = s.mtval;
        mie = s.mie;              mip = s.mip;
    endtask

    task automatic apply_idle();
        stim_t s;
        s = blank();
        s.valid = 1'b0;
        apply(s);
    endtask

    // Reference: ordered candidate lists, first hit wins; MRET only when nothing else fires
    function automatic void model(input stim_t s, input logic [1:0] p, output bit ev, output exp_t e);
        bit          f[6];
        logic [3:0]  cd[6];
        logic [63:0] tv[6];
        int          ids[3];
        logic [63:0] pend, cause, tval, vec_off;
        bit          hit, ien;
        f[0] = s.fm;  cd[0] = 4'd0; tv[0] = s.pc;
        f[1] = s.ill || (s.mret && p != 2'd3); cd[1] = 4'd2; tv[1] = 64'd0;
        f[2] = s.csr; cd[2] = s.csr_code; tv[2] = s.csr_val;
        f[3] = s.eb;  cd[3] = 4'd3; tv[3] = s.pc;
        f[4] = s.ec;  cd[4] = (p == 2'd0) ? 4'd8 : (p == 2'd1) ? 4'd9 : 4'd11; tv[4] = 64'd0;
        f[5] = s.lsm; cd[5] = s.lss ? 4'd6 : 4'd4; tv[5] = s.ls_addr;
        ids[0] = 11; ids[1] = 3; ids[2] = 7;
        pend = s.mip & s.mie;
        ien  = (p != 2'd3) || s.mstatus[3];
        hit = 0; cause = 0; tval = 0; vec_off = 0;
        for (int i = 0; i < 6; i++)
            if (!hit && f[i]) begin hit = 1; cause = 64'(cd[i]); tval = tv[i]; end
        if (!hit && ien)
            for (int j = 0; j < 3; j++)
                if (!hit && pend[ids[j]]) begin
                    hit = 1;
                    cause = 64'h8000_0000_0000_0000 | 64'(ids[j]);
                    vec_off = (s.mtvec[1:0] == 2'b01) ? 64'(4 * ids[j]) : 64'd0;
                end
        e = '{default: '0};
        if (hit) begin
            e.is_ret  = 1'b0;
            e.mepc    = s.pc & ~64'd1;
            e.mcause  = cause;
            e.mtval   = tval;
            e.mstatus = (s.mstatus & ~64'h1888) | (64'(s.mstatus[3]) << 7) | (64'(p) << 11);
            e.target  = (s.mtvec & ~64'd3) + vec_off;
            e.priv    = 2'd3;
        end else begin
            e.is_ret  = 1'b1;
            e.mepc    = s.mepc;
            e.mcause  = s.mcause;
            e.mtval   = s.mtval;
            e.mstatus = (s.mstatus & ~64'h1888) | (64'(s.mstatus[7]) << 3) | 64'h80;
            e.target  = s.mepc & ~64'd3;
            e.priv    = (s.mstatus[12:11] == 2'b10) ? 2'd0 : s.mstatus[12:11];
        end
        ev = s.valid && (hit || s.mret);
    endfunction

    // One retire-boundary cycle plus the full sequence it triggers
    task automatic do_txn(input string nm, input stim_t s, input bit ev, input exp_t e, input bit garb);
        stim_t g;
        apply(s);
        #1;
        chk({nm, " stall@N"}, 64'(stall), 64'(ev));
        @(posedge clk); #1;
        if (!ev) begin
            chk({nm, " no trap_taken"}, 64'(trap_taken), 64'd0);
            chk({nm, " no trap_done"}, 64'(trap_done), 64'd0);
            apply_idle();
            return;
        end
        if (garb) apply(rand_stim(1'b1)); else apply_idle();
        chk({nm, " trap_taken@N+1"}, 64'(trap_taken), 64'(!e.is_ret));
        chk({nm, " trap_done@N+1"}, 64'(trap_done), 64'(e.is_ret));
        chk({nm, " mepc_next"}, mepc_next, e.mepc);
        chk({nm, " mcause_next"}, mcause_next, e.mcause);
        chk({nm, " mtval_next"}, mtval_next, e.mtval);
        chk({nm, " mstatus_next"}, mstatus_next, e.mstatus);
        chk({nm, " stall@N+1"}, 64'(stall), 64'd1);
        chk({nm, " redirect_valid@N+1"}, 64'(redirect_valid), 64'd0);
        chk({nm, " priv@N+1"}, 64'(priv_lvl), 64'(model_priv));
        @(posedge clk); #1;
        if (garb) begin
            g = rand_stim(1'b1);
            g.eb = 1'b1;
            apply(g);
        end
        chk({nm, " redirect_valid@N+2"}, 64'(redirect_valid), 64'd1);
        chk({nm, " redirect_pc"}, redirect_pc, e.target);
        chk({nm, " priv@N+2"}, 64'(priv_lvl), 64'(e.priv));
        chk({nm, " pulses@N+2"}, 64'({trap_taken, trap_done}), 64'd0);
        chk({nm, " stall@N+2"}, 64'(stall), 64'd1);
        #2;
        apply_idle();
        @(posedge clk); #1;
        chk({nm, " idle@N+3"}, 64'({redirect_valid, trap_taken, trap_done, stall}), 64'd0);
        model_priv = e.priv;
    endtask

    task automatic model_txn(input string nm, input stim_t s, input bit garb);
        bit   ev;
        exp_t e;
        model(s, model_priv, ev, e);
        do_txn(nm, s, ev, e, garb);
    endtask

    // Drive the hart to privilege p through a trap and/or an MRET
    task automatic set_priv(input logic [1:0] p);
        stim_t s;
        if (model_priv != 2'd3) begin
            s = blank(); s.ec = 1'b1; s.pc = 64'h40; s.mtvec = 64'h800;
            model_txn("to_m", s, 1'b0);
        end
        if (p != 2'd3) begin
            s = blank(); s.mret = 1'b1; s.mstatus = 64'(p) << 11; s.mepc = 64'h100;
            model_txn("to_low", s, 1'b0);
        end
    endtask

    vec_t v[8];

    initial begin
        for (int i = 0; i < 8; i++) v[i].s = blank();
        v[0].pre = 2'd0; v[0].s.ec = 1; v[0].s.pc = 64'h1000; v[0].s.mtvec = 64'h8000_0000;
        v[0].e = '{is_ret: 0, mepc: 64'h1000, mcause: 64'd8, mtval: 64'd0, mstatus: 64'd0, target: 64'h8000_0000, priv: 2'd3};
        v[1].pre = 2'd3; v[1].s.mip = 64'h80; v[1].s.mie = 64'h80; v[1].s.mstatus = 64'h8;
        v[1].s.mtvec = 64'h8000_0001; v[1].s.pc = 64'h2004;
        v[1].e = '{is_ret: 0, mepc: 64'h2004, mcause: 64'h8000_0000_0000_0007, mtval: 64'd0, mstatus: 64'h1880, target: 64'h8000_001C, priv: 2'd3};
        v[2].pre = 2'd3; v[2].s.mret = 1; v[2].s.mstatus = 64'h80; v[2].s.mepc = 64'h2004;
        v[2].s.mcause = 64'h8000_0000_0000_0007; v[2].s.mtval = 64'h55;
        v[2].e = '{is_ret: 1, mepc: 64'h2004, mcause: 64'h8000_0000_0000_0007, mtval: 64'h55, mstatus: 64'h88, target: 64'h2004, priv: 2'd0};
        v[3].pre = 2'd3; v[3].s.ill = 1; v[3].s.lsm = 1; v[3].s.ls_addr = 64'hBAD; v[3].s.mip = 64'h800;
        v[3].s.mie = 64'h800; v[3].s.mstatus = 64'h8; v[3].s.mtvec = 64'h8000_0001; v[3].s.pc = 64'h3000;
        v[3].e = '{is_ret: 0, mepc: 64'h3000, mcause: 64'd2, mtval: 64'd0, mstatus: 64'h1880, target: 64'h8000_0000, priv: 2'd3};
        v[4].pre = 2'd0; v[4].s.mret = 1; v[4].s.pc = 64'h4003; v[4].s.mtvec = 64'h100; v[4].s.mepc = 64'h9990;
        v[4].e = '{is_ret: 0, mepc: 64'h4002, mcause: 64'd2, mtval: 64'd0, mstatus: 64'd0, target: 64'h100, priv: 2'd3};
        v[5].pre = 2'd1; v[5].s.fm = 1; v[5].s.eb = 1; v[5].s.pc = 64'h5001; v[5].s.mstatus = 64'h8;
        v[5].s.mtvec = 64'h9000_0001;
        v[5].e = '{is_ret: 0, mepc: 64'h5000, mcause: 64'd0, mtval: 64'h5001, mstatus: 64'h880, target: 64'h9000_0000, priv: 2'd3};
        v[6].pre = 2'd3; v[6].s.lsm = 1; v[6].s.lss = 1; v[6].s.ls_addr = 64'hDEAD; v[6].s.pc = 64'h6000;
        v[6].s.mtvec = 64'h200;
        v[6].e = '{is_ret: 0, mepc: 64'h6000, mcause: 64'd6, mtval: 64'hDEAD, mstatus: 64'h1800, target: 64'h200, priv: 2'd3};
        v[7].pre = 2'd3; v[7].s.csr = 1; v[7].s.csr_code = 4'd2; v[7].s.csr_val = 64'h305; v[7].s.eb = 1;
        v[7].s.mstatus = 64'h8; v[7].s.mtvec = 64'h301; v[7].s.pc = 64'h7000;
        v[7].e = '{is_ret: 0, mepc: 64'h7000, mcause: 64'd2, mtval: 64'h305, mstatus: 64'h1880, target: 64'h300, priv: 2'd3};

        // Reset state
        apply_idle();
        repeat (2) @(posedge clk);
        #1;
        chk("reset pulses", 64'({trap_taken, trap_done, redirect_valid}), 64'd0);
        chk("reset mepc_next", mepc_next, 64'd0);
        chk("reset mcause_next", mcause_next, 64'd0);
        chk("reset mtval_next", mtval_next, 64'd0);
        chk("reset mstatus_next", mstatus_next, 64'd0);
        chk("reset redirect_pc", redirect_pc, 64'd0);
        chk("reset priv", 64'(priv_lvl), 64'd3);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; garbage (including ebreak in REDIRECT) must be ignored
        for (int i = 0; i < 8; i++) begin
            set_priv(v[i].pre);
            do_txn($sformatf("vec%0d", i), v[i].s, 1'b1, v[i].e, 1'b1);
        end

        // Random stimulus against the reference model
        for (int i = 0; i < 300; i++)
            model_txn($sformatf("rnd%0d", i), rand_stim(1'b0), 1'($urandom_range(0, 1)));

        // Reset during TRAP_COMMIT aborts the sequence
        set_priv(2'd0);
        begin
            stim_t s;
            s = blank(); s.ec = 1'b1; s.pc = 64'h1234; s.mtvec = 64'h8000;
            apply(s);
            @(posedge clk); #1;
            apply_idle();
            chk("abort trap_taken before rst", 64'(trap_taken), 64'd1);
            rst = 1'b1;
            #1;
            chk("abort pulses", 64'({trap_taken, trap_done, redirect_valid}), 64'd0);
            chk("abort mepc_next", mepc_next, 64'd0);
            chk("abort mcause_next", mcause_next, 64'd0);
            chk("abort redirect_pc", redirect_pc, 64'd0);
            chk("abort priv", 64'(priv_lvl), 64'd3);
            chk("abort stall", 64'(stall), 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            model_priv = 2'd3;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk); #1;
                chk("abort no pulse after release", 64'({redirect_valid, trap_taken, trap_done}), 64'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
